// File: rtl/xalu_seq.sv
// xalu_seq: runs one WIDTH-bit op through a single 4-bit ALU slice, one nibble per clock.
// Ports: host start/ready/done + op_*/result/flags; alu_* drive/observe the slice. Macro XALU_SEQ_SUB_EN enables SUB (op_f=9).
module xalu_seq #(
  parameter int NIBBLES = 4,
  localparam int WIDTH = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       op_f,
  input  logic             op_cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ones,
  output logic             equ,
  output logic             err,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_f,
  output logic             alu_ci_left,
  output logic             alu_ci_right,
  input  logic [3:0]       alu_d,
  input  logic             alu_co_left,
  input  logic             alu_co_right,
  input  logic             alu_equ,
  input  logic             alu_zero
);

  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       f_q, f_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;
  logic             equ_q, equ_d;
  logic             err_q, err_d;

  logic       legal_in;
  logic       is_add, is_shl, is_shr, is_sub;
  logic       last;
  logic [3:0] a_nib, b_nib;

`ifdef XALU_SEQ_SUB_EN
  assign legal_in = (op_f <= 4'd9);
  assign is_sub   = (f_q == 4'd9);
`else
  assign legal_in = (op_f <= 4'd8);
  assign is_sub   = 1'b0;
`endif

  assign is_add = (f_q == 4'd0);
  assign is_shr = (f_q == 4'd6);
  assign is_shl = (f_q == 4'd7);
  assign last   = is_shr ? (idx_q == '0) : (idx_q == LAST);
  assign a_nib  = a_q[idx_q*4 +: 4];
  assign b_nib  = b_q[idx_q*4 +: 4];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    f_d     = f_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    ones_d  = ones_q;
    equ_d   = equ_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          f_d     = op_f;
          res_d   = '0;
          err_d   = !legal_in;
          zero_d  = 1'b1;
          ones_d  = legal_in;
          equ_d   = legal_in;
          idx_d   = (op_f == 4'd6) ? LAST : '0;
          carry_d = op_cin;
`ifdef XALU_SEQ_SUB_EN
          // Subtract as A + ~B + ~borrow_in.
          if (op_f == 4'd9) carry_d = !op_cin;
`endif
          state_d = legal_in ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        res_d[idx_q*4 +: 4] = alu_d;
        zero_d = zero_q & alu_zero;
        ones_d = ones_q & (alu_d == 4'hF);
        equ_d  = equ_q & alu_equ;
        if (is_add || is_shl || is_sub)
          carry_d = alu_co_left;
        else if (is_shr)
          carry_d = alu_co_right;
        if (last)
          state_d = S_DONE;
        else
          idx_d = is_shr ? idx_q - 1'b1 : idx_q + 1'b1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_a        = '0;
    alu_b        = '0;
    alu_f        = '0;
    alu_ci_left  = 1'b0;
    alu_ci_right = 1'b0;
    if (state_q == S_RUN) begin
      alu_a = a_nib;
      alu_b = is_sub ? ~b_nib : b_nib;
      alu_f = is_sub ? 4'd0 : f_q;
      if (is_add || is_shl || is_sub)
        alu_ci_right = carry_q;
      if (is_shr)
        alu_ci_left = carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      f_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      ones_q  <= 1'b0;
      equ_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      f_q     <= f_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      ones_q  <= ones_d;
      equ_q   <= equ_d;
      err_q   <= err_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = res_q;
  assign zero   = zero_q;
  assign ones   = ones_q;
  assign err    = err_q;
  // SUB reuses the zero accumulator: A-B == 0 exactly when A == B.
  assign equ    = is_sub ? zero_q : equ_q;
  // A latched illegal code is never ADD/SHL/SHR/SUB, so cout reads 0.
  assign cout   = is_sub ? !carry_q :
                  (is_add || is_shl || is_shr) ? carry_q : 1'b0;

endmodule

// File: tb/tb_xalu_seq.sv
// tb_xalu_seq: directed + random checks of xalu_seq (NIBBLES=4) with a behavioural 4-bit slice.
// Expected values come from a full-width arithmetic model of each function code.
module tb_xalu_seq;

  localparam int NIB = 4;
  localparam int W   = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic [3:0]   op_f = '0;
  logic         op_cin = 1'b0;
  logic         ready, done, cout, zero, ones, equ, err;
  logic [W-1:0] result;
  logic [3:0]   alu_a, alu_b, alu_f, alu_d;
  logic         alu_ci_left, alu_ci_right;
  logic         alu_co_left, alu_co_right, alu_equ, alu_zero;

  int total = 0;
  int bad = 0;

  xalu_seq #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst(rst), .start(start),
    .op_a(op_a), .op_b(op_b), .op_f(op_f), .op_cin(op_cin),
    .ready(ready), .done(done), .result(result), .cout(cout),
    .zero(zero), .ones(ones), .equ(equ), .err(err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_ci_left(alu_ci_left), .alu_ci_right(alu_ci_right),
    .alu_d(alu_d), .alu_co_left(alu_co_left), .alu_co_right(alu_co_right),
    .alu_equ(alu_equ), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit slice.
  always_comb begin
    logic [4:0] s;
    s            = 5'(alu_a) + 5'(alu_b) + 5'(alu_ci_right);
    alu_d        = '0;
    alu_co_left  = 1'b0;
    alu_co_right = 1'b0;
    case (alu_f)
      4'd0: begin alu_d = s[3:0]; alu_co_left = s[4]; end
      4'd1: alu_d = alu_a & alu_b;
      4'd2: alu_d = alu_a | alu_b;
      4'd3: alu_d = alu_a ^ alu_b;
      4'd4: alu_d = alu_a;
      4'd5: alu_d = alu_b;
      4'd6: begin alu_d = {alu_ci_left, alu_a[3:1]}; alu_co_right = alu_a[0]; end
      4'd7: begin alu_d = {alu_a[2:0], alu_ci_right}; alu_co_left = alu_a[3]; end
      4'd8: alu_d = ~alu_a;
      default: alu_d = '0;
    endcase
    alu_equ  = (alu_a == alu_b);
    alu_zero = (alu_d == 4'h0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full-width reference of one operation.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] f, input logic c,
                       output logic [W-1:0] r, output logic co,
                       output logic eq, output logic il);
    logic [W:0] s;
    r = '0; co = 1'b0; il = 1'b0; eq = (a == b);
    case (f)
      4'd0: begin s = {1'b0, a} + {1'b0, b} + (W+1)'(c); r = s[W-1:0]; co = s[W]; end
      4'd1: r = a & b;
      4'd2: r = a | b;
      4'd3: r = a ^ b;
      4'd4: r = a;
      4'd5: r = b;
      4'd6: begin r = {c, a[W-1:1]}; co = a[0]; end
      4'd7: begin r = {a[W-2:0], c}; co = a[W-1]; end
      4'd8: r = ~a;
`ifdef XALU_SEQ_SUB_EN
      4'd9: begin
        s  = {1'b0, a} + {1'b0, ~b} + (W+1)'(!c);
        r  = s[W-1:0];
        co = !s[W];
        eq = (a == b);
      end
`endif
      default: il = 1'b1;
    endcase
  endtask

  logic [3:0] aseq [0:NIB-1];
  int         lat;
  logic       rdy_run;

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] f, input logic c, input bit inj);
    @(negedge clk);
    op_a = a; op_b = b; op_f = f; op_cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    rdy_run = 1'b0;
    while (!done && lat < 20) begin
      if (lat <= NIB) aseq[lat-1] = alu_a;
      rdy_run = rdy_run | ready;
      start = inj && (lat == 2);
      if (start) op_a = ~a;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [3:0] f,
                          input logic c, input bit inj);
    logic [W-1:0] er;
    logic eco, eeq, eil;
    model(a, b, f, c, er, eco, eeq, eil);
    run_op(a, b, f, c, inj);
    chk({tag, "_lat"}, lat, eil ? 1 : NIB + 1);
    chk({tag, "_rdy"}, rdy_run, 0);
    chk({tag, "_res"}, result, er);
    chk({tag, "_cout"}, cout, eco);
    chk({tag, "_err"}, err, eil);
    chk({tag, "_zero"}, zero, er == '0);
    if (!eil) begin
      chk({tag, "_ones"}, ones, er == '1);
      chk({tag, "_equ"}, equ, eeq);
    end
    @(negedge clk);
    chk({tag, "_pulse"}, done, 0);
    chk({tag, "_idle"}, ready, 1);
  endtask

  initial begin
    logic seen;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_zero", zero, 1);
    chk("rst_ones", ones, 0);
    chk("rst_equ", equ, 0);
    chk("rst_err", err, 0);
    chk("rst_alu", {alu_a, alu_b, alu_f, alu_ci_left, alu_ci_right}, 0);

    check_op("add1", 16'h1234, 16'h0FFF, 4'd0, 1'b0, 0);
    chk("add1_const", result, 16'h2233);
    chk("add1_equ", equ, 0);
    check_op("add2", 16'hFFFF, 16'h0001, 4'd0, 1'b0, 0);
    chk("add2_const", {cout, zero, result}, {2'b11, 16'h0000});
    check_op("xor", 16'hA5A5, 16'hA5A5, 4'd3, 1'b0, 0);
    chk("xor_const", {equ, zero, cout}, 3'b110);
    check_op("shr", 16'h8001, 16'h0000, 4'd6, 1'b1, 0);
    chk("shr_const", {cout, result}, {1'b1, 16'hC000});
    chk("shr_seq", {aseq[0], aseq[1], aseq[2], aseq[3]}, 16'h8001);
    check_op("shl", 16'h8001, 16'h0000, 4'd7, 1'b0, 0);
    chk("shl_const", {cout, result}, {1'b1, 16'h0002});
    check_op("ill", 16'h1111, 16'h2222, 4'hA, 1'b1, 0);
    chk("ill_const", {err, result}, {1'b1, 16'h0000});
    check_op("com", 16'h0000, 16'h1234, 4'd8, 1'b0, 0);
    chk("com_const", {ones, err, result}, {2'b10, 16'hFFFF});
    check_op("f9", 16'h0005, 16'h0007, 4'd9, 1'b0, 0);
`ifdef XALU_SEQ_SUB_EN
    chk("sub1_const", {cout, ones, result}, {2'b10, 16'hFFFE});
    check_op("sub2", 16'h1234, 16'h1234, 4'd9, 1'b0, 0);
    chk("sub2_const", {cout, equ, result}, {2'b01, 16'h0000});
`else
    chk("f9_illegal", err, 1);
`endif

    // Reset during the second RUN cycle.
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h0FFF; op_f = 4'd0; op_cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_result", result, 0);
    seen = done;
    repeat (8) begin
      @(negedge clk);
      seen = seen | done;
    end
    chk("abort_nodone", seen, 0);

    check_op("ignore", 16'h4321, 16'h1111, 4'd0, 1'b1, 1);

    for (int i = 0; i < 60; i++) begin
      logic [3:0] f;
      f = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15))
                                      : 4'($urandom_range(0, 9));
      check_op($sformatf("rnd%0d", i), 16'($urandom), 16'($urandom),
               f, 1'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
